// File: rtl/prog_rom.sv
`default_nettype none
// ============================================================================
// Module   : prog_rom
// Brief    : Program ROM with a default 14-word image, 1-cycle registered read
//            and an optional load port enabled by macro PROG_ROM_LOAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module prog_rom #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] adrs,
    input  logic              rd,
`ifdef PROG_ROM_LOAD_EN
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
`endif
    output logic [DATA_W-1:0] dout,
    output logic              dvalid,
    output logic              oor,
    output logic              busy
);

    localparam int                c_IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    function automatic logic [DATA_W-1:0] img(input int idx);
        logic [7:0] b;
        case (idx)
            0:       b = 8'h01;
            1:       b = 8'h20;
            2:       b = 8'h05;
            3:       b = 8'h22;
            4:       b = 8'h03;
            5:       b = 8'h20;
            6:       b = 8'h05;
            7:       b = 8'h23;
            8:       b = 8'h02;
            9:       b = 8'h22;
            10:      b = 8'h04;
            11:      b = 8'h22;
            12:      b = 8'h06;
            13:      b = 8'h02;
            default: b = 8'h00;
        endcase
        return DATA_W'(b);
    endfunction

    logic              w_in_range;
    logic              w_rd_ok;
    logic [DATA_W-1:0] w_rd_word;

    assign w_in_range = ({1'b0, adrs} < c_DEPTH_EXT);

`ifdef PROG_ROM_LOAD_EN
    localparam logic [1:0]        c_IDLE = 2'd0;
    localparam logic [1:0]        c_LOAD = 2'd1;
    localparam logic [1:0]        c_DONE = 2'd2;
    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] w_last_calc;
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Zero length, or any length beyond the array, loads the whole array.
    assign w_last_calc = (ld_len == '0 || {1'b0, ld_len} > c_DEPTH_EXT) ? c_LAST
                                                                       : ld_len - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (ld_start) w_state_nxt = c_LOAD;
            c_LOAD:  if (ld_valid && r_ptr == r_last) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= '0;
            r_last <= '0;
        end else if (r_state == c_IDLE && ld_start) begin
            r_ptr  <= '0;
            r_last <= w_last_calc;
        end else if (r_state == c_LOAD && ld_valid) begin
            r_ptr  <= r_ptr + 1'b1;
        end
    end

    // Reset reloads the default image, discarding any partial load.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= img(i);
        end else if (r_state == c_LOAD && ld_valid) begin
            r_mem[r_ptr[c_IDX_W-1:0]] <= ld_data;
        end
    end

    assign ld_ready  = (r_state == c_LOAD);
    assign ld_done   = (r_state == c_DONE);
    assign busy      = (r_state != c_IDLE);
    assign w_rd_ok   = rd && (r_state == c_IDLE);
    assign w_rd_word = r_mem[adrs[c_IDX_W-1:0]];
`else
    logic [DATA_W-1:0] w_rom [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign w_rom[gi] = img(gi);
    end

    assign busy      = 1'b0;
    assign w_rd_ok   = rd;
    assign w_rd_word = w_rom[adrs[c_IDX_W-1:0]];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            dout   <= '0;
            dvalid <= 1'b0;
            oor    <= 1'b0;
        end else begin
            dvalid <= w_rd_ok;
            oor    <= w_rd_ok && !w_in_range;
            if (w_rd_ok) dout <= w_in_range ? w_rd_word : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_rom.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_rom
// Brief    : Vector-table bench for prog_rom (DEPTH=16); load sequences are
//            exercised when PROG_ROM_LOAD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_rom;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              r_rd;
    logic [ADDR_W-1:0] r_adrs;
    logic [DATA_W-1:0] w_dout;
    logic              w_dvalid;
    logic              w_oor;
    logic              w_busy;
`ifdef PROG_ROM_LOAD_EN
    logic              r_ld_start;
    logic [ADDR_W-1:0] r_ld_len;
    logic              r_ld_valid;
    logic [DATA_W-1:0] r_ld_data;
    logic              w_ld_ready;
    logic              w_ld_done;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    prog_rom #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .adrs     (r_adrs),
        .rd       (r_rd),
`ifdef PROG_ROM_LOAD_EN
        .ld_start (r_ld_start),
        .ld_len   (r_ld_len),
        .ld_valid (r_ld_valid),
        .ld_data  (r_ld_data),
        .ld_ready (w_ld_ready),
        .ld_done  (w_ld_done),
`endif
        .dout     (w_dout),
        .dvalid   (w_dvalid),
        .oor      (w_oor),
        .busy     (w_busy)
    );

    typedef struct {
        logic              rd;
        logic [ADDR_W-1:0] adrs;
        logic              e_dvalid;
        logic [DATA_W-1:0] e_dout;
        logic              e_oor;
    } vec_t;

    vec_t tv [21];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic e_dv, input logic [DATA_W-1:0] e_do,
                         input logic e_oor, input logic e_busy);
        n_vec++;
        if (w_dvalid !== e_dv || w_dout !== e_do || w_oor !== e_oor || w_busy !== e_busy) begin
            n_err++;
            $display("FAIL %s: got dvalid=%b dout=%h oor=%b busy=%b, want dvalid=%b dout=%h oor=%b busy=%b",
                     name, w_dvalid, w_dout, w_oor, w_busy, e_dv, e_do, e_oor, e_busy);
        end
    endtask

`ifdef PROG_ROM_LOAD_EN
    task automatic check_ld(input string name, input logic e_rdy, input logic e_done);
        n_vec++;
        if (w_ld_ready !== e_rdy || w_ld_done !== e_done) begin
            n_err++;
            $display("FAIL %s: got ld_ready=%b ld_done=%b, want ld_ready=%b ld_done=%b",
                     name, w_ld_ready, w_ld_done, e_rdy, e_done);
        end
    endtask
`endif

    initial begin
        logic [DATA_W-1:0] img [14];
        img = '{8'h01, 8'h20, 8'h05, 8'h22, 8'h03, 8'h20, 8'h05,
                8'h23, 8'h02, 8'h22, 8'h04, 8'h22, 8'h06, 8'h02};
        for (int i = 0; i < 14; i++) tv[i] = '{1'b1, ADDR_W'(i), 1'b1, img[i], 1'b0};
        tv[14] = '{1'b1, 8'h0F, 1'b1, 8'h00, 1'b0};
        tv[15] = '{1'b1, 8'h20, 1'b1, 8'h00, 1'b1};
        tv[16] = '{1'b1, 8'h03, 1'b1, 8'h22, 1'b0};
        tv[17] = '{1'b0, 8'h05, 1'b0, 8'h22, 1'b0};
        tv[18] = '{1'b1, 8'h10, 1'b1, 8'h00, 1'b1};
        tv[19] = '{1'b1, 8'hFF, 1'b1, 8'h00, 1'b1};
        tv[20] = '{1'b1, 8'h0D, 1'b1, 8'h02, 1'b0};

        rst    = 1'b1;
        r_rd   = 1'b1;
        r_adrs = 8'h01;
`ifdef PROG_ROM_LOAD_EN
        r_ld_start = 1'b1;
        r_ld_len   = 8'd2;
        r_ld_valid = 1'b1;
        r_ld_data  = 8'h5A;
`endif
        tick();
        tick();
        check("reset", 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef PROG_ROM_LOAD_EN
        check_ld("reset_ld", 1'b0, 1'b0);
        r_ld_start = 1'b0;
        r_ld_valid = 1'b0;
`endif
        rst  = 1'b0;
        r_rd = 1'b0;

        for (int i = 0; i < 21; i++) begin
            r_rd   = tv[i].rd;
            r_adrs = tv[i].adrs;
            tick();
            check($sformatf("vec%0d", i), tv[i].e_dvalid, tv[i].e_dout, tv[i].e_oor, 1'b0);
        end
        r_rd = 1'b0;
        tick();
        check("idle_hold", 1'b0, 8'h02, 1'b0, 1'b0);

`ifdef PROG_ROM_LOAD_EN
        // ld_valid outside LOAD must not write.
        r_ld_valid = 1'b1;
        r_ld_data  = 8'h55;
        r_rd       = 1'b1;
        r_adrs     = 8'h00;
        tick();
        check("ldv_idle_rd", 1'b1, 8'h01, 1'b0, 1'b0);
        r_ld_valid = 1'b0;
        tick();
        check("ldv_idle_nowrite", 1'b1, 8'h01, 1'b0, 1'b0);

        r_ld_start = 1'b1;
        r_ld_len   = 8'd3;
        r_adrs     = 8'h02;
        tick();
        check("rd_with_start", 1'b1, 8'h05, 1'b0, 1'b1);
        check_ld("load_entry", 1'b1, 1'b0);
        r_ld_start = 1'b0;
        r_ld_len   = 8'd0;
        r_rd       = 1'b0;
        r_ld_valid = 1'b1;
        r_ld_data  = 8'hAA;
        tick();
        check_ld("w_aa", 1'b1, 1'b0);
        r_ld_data  = 8'hBB;
        tick();
        check_ld("w_bb", 1'b1, 1'b0);
        r_ld_valid = 1'b0;
        r_ld_start = 1'b1;
        r_ld_len   = 8'd8;
        r_rd       = 1'b1;
        r_adrs     = 8'h00;
        tick();
        check("rd_in_load", 1'b0, 8'h05, 1'b0, 1'b1);
        check_ld("gap", 1'b1, 1'b0);
        r_ld_start = 1'b0;
        r_rd       = 1'b0;
        r_ld_valid = 1'b1;
        r_ld_data  = 8'hCC;
        tick();
        check("busy_done", 1'b0, 8'h05, 1'b0, 1'b1);
        check_ld("done_pulse", 1'b0, 1'b1);
        r_ld_valid = 1'b0;
        tick();
        check("idle_again", 1'b0, 8'h05, 1'b0, 1'b0);
        check_ld("done_end", 1'b0, 1'b0);
        begin
            logic [DATA_W-1:0] exp4 [4];
            exp4 = '{8'hAA, 8'hBB, 8'hCC, 8'h22};
            for (int i = 0; i < 4; i++) begin
                r_rd   = 1'b1;
                r_adrs = ADDR_W'(i);
                tick();
                check($sformatf("loaded%0d", i), 1'b1, exp4[i], 1'b0, 1'b0);
            end
        end

        // Reset in the middle of a 5-word load.
        r_rd       = 1'b0;
        r_ld_start = 1'b1;
        r_ld_len   = 8'd5;
        tick();
        r_ld_start = 1'b0;
        r_ld_valid = 1'b1;
        r_ld_data  = 8'h77;
        tick();
        r_ld_data  = 8'h88;
        tick();
        check_ld("midload", 1'b1, 1'b0);
        rst        = 1'b1;
        r_ld_data  = 8'h99;
        r_rd       = 1'b1;
        r_adrs     = 8'h00;
        tick();
        check("rst_midload", 1'b0, 8'h00, 1'b0, 1'b0);
        check_ld("rst_ld", 1'b0, 1'b0);
        rst        = 1'b0;
        r_ld_valid = 1'b0;
        begin
            logic [DATA_W-1:0] exp3 [3];
            exp3 = '{8'h01, 8'h20, 8'h05};
            for (int i = 0; i < 3; i++) begin
                r_adrs = ADDR_W'(i);
                tick();
                check($sformatf("restored%0d", i), 1'b1, exp3[i], 1'b0, 1'b0);
            end
        end
        r_rd = 1'b0;
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_rom.md
PROG_ROM -- requirements
Module: prog_rom

Interface
REQ-001 Parameter DATA_W, default 8, width of one program word.
REQ-002 Parameter ADDR_W, default 8, address width.
REQ-003 Parameter DEPTH, default 256, number of implemented words; legal range 14 to 2**ADDR_W.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 adrs  input  ADDR_W  read address.
REQ-007 rd  input  1  read request, sampled each cycle.
REQ-008 dout  output  DATA_W  registered read data.
REQ-009 dvalid  output  1  one-cycle pulse, dout valid.
REQ-010 oor  output  1  one-cycle pulse with dvalid, address was >= DEPTH.
REQ-011 busy  output  1  high while a load is in progress.
REQ-012 ld_start, ld_len[ADDR_W], ld_valid, ld_data[DATA_W]  inputs; ld_ready, ld_done  outputs; present only with PROG_ROM_LOAD_EN.

Function
REQ-013 Storage SHALL be a DEPTH x DATA_W register array holding the default image: words 0..13 = 01,20,05,22,03,20,05,23,02,22,04,22,06,02 (hex, zero-extended to DATA_W); all other words 0.
REQ-014 Read latency SHALL be exactly 1 cycle: rd=1 at edge N with busy=0 -> dout=mem[adrs], dvalid=1 after edge N.
REQ-015 dout SHALL hold its last value when dvalid=0; it never drives X.
REQ-016 adrs >= DEPTH with rd=1 -> dout=0, dvalid=1, oor=1 in the same cycle.
REQ-017 Back-to-back rd SHALL give one result per cycle, no bubbles.
REQ-018 FSM states: IDLE, LOAD, DONE; reset state IDLE.
REQ-019 IDLE -> LOAD on ld_start=1; the load write pointer clears to 0 and ld_len is latched; ld_len=0 means DEPTH words.
REQ-020 In LOAD: ld_ready=1; each cycle with ld_valid=1 writes ld_data to mem[ptr] and increments ptr.
REQ-021 LOAD -> DONE on the edge that writes the last word (ptr = len-1, or DEPTH-1 if len > DEPTH).
REQ-022 DONE: ld_done=1 for exactly one cycle, then IDLE.
REQ-023 busy=1 in LOAD and DONE; rd while busy is dropped: no dvalid, no queued read.
REQ-024 ld_start outside IDLE SHALL be ignored.
REQ-025 rd and ld_start in the same cycle in IDLE: the read completes normally and the load starts; busy rises on the following cycle.
REQ-026 ld_valid while ld_ready=0 SHALL be ignored; no write.

Reset
REQ-027 rst=1 at an edge: dout=0, dvalid=0, oor=0, busy=0, ld_ready=0, ld_done=0, FSM=IDLE, ptr=0.
REQ-028 Reset SHALL restore the default image to every word, including in the middle of a load; partial load data is discarded.
REQ-029 rd, ld_start and ld_valid SHALL be ignored during any cycle in which rst=1.

Configuration
REQ-030 Macro PROG_ROM_LOAD_EN defined: the load ports, FSM and write path are present as specified.
REQ-031 Macro PROG_ROM_LOAD_EN undefined: the load ports are absent; busy is tied to 0; memory is constant at the default image; read behaviour is unchanged.

Verification
REQ-032 After reset, rd=1 on adrs=00..0D in consecutive cycles -> dvalid on 14 consecutive cycles, dout=01,20,05,22,03,20,05,23,02,22,04,22,06,02.
REQ-033 DEPTH=16, rd=1 at adrs=20 -> dout=00, dvalid=1, oor=1 one cycle later; adrs=0F -> dout=00, oor=0.
REQ-034 ld_start with ld_len=3, then ld_data AA,BB,CC with a ld_valid gap after BB -> busy high, ld_done pulses once after CC; reads of 0..3 return AA,BB,CC,22.
REQ-035 rd=1 during LOAD -> no dvalid; ld_start during LOAD -> no restart, pointer continues.
REQ-036 rst asserted after 2 of 5 load words -> busy=0 next cycle; a read of adrs=00 returns 01.
REQ-037 Build without PROG_ROM_LOAD_EN -> REQ-032 and REQ-033 pass; busy stays 0 throughout.
